// File: rtl/counter_ctrl.sv
// Three-key debounced front end for an accumulating counter: load (key 0), hold toggle (key 1), clear (key 2).
// Define COUNTER_CTRL_AUTOREPEAT_EN to compile in auto-repeat loads while key 0 stays pressed.
module counter_ctrl #(
    parameter int DB_CYCLES     = 2_000_000,
    parameter int REPEAT_CYCLES = 50_000_000
) (
    input  logic       clk100_i,
    input  logic       rst_i,
    input  logic [2:0] key_i,
    input  logic [9:0] sw_i,
    output logic       load_o,
    output logic       clear_o,
    output logic [9:0] data_o,
    output logic       hold_o,
    output logic [1:0] state_o
);

    localparam int CW = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);
    localparam logic [CW-1:0] DB_MAX  = CW'(DB_CYCLES);

    if (DB_CYCLES < 2 || DB_CYCLES > 24'hFF_FFFF || REPEAT_CYCLES < 1) begin : g_param_check
        $error("counter_ctrl: DB_CYCLES or REPEAT_CYCLES out of range");
    end

    typedef enum logic [1:0] {
        IDLE       = 2'b00,
        DB_PRESS   = 2'b01,
        PRESSED    = 2'b10,
        DB_RELEASE = 2'b11
    } key_state_t;

    key_state_t    st   [3];
    logic [CW-1:0] cnt  [3];
    logic [2:0]    sync_a;
    logic [2:0]    sync_b;
    logic [2:0]    low;
    logic [2:0]    evt;
    logic          load_evt;
    logic          load_ok;

    // Reset value 1 models released buttons so reset never looks like a press.
    always_ff @(posedge clk100_i or posedge rst_i) begin
        if (rst_i) begin
            sync_a <= 3'b111;
            sync_b <= 3'b111;
        end else begin
            sync_a <= key_i;
            sync_b <= sync_a;
        end
    end

    assign low = ~sync_b;

    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    always_comb begin
        evt = '0;
        for (int i = 0; i < 3; i++) begin
            evt[i] = (st[i] == DB_PRESS) && low[i] && (cnt[i] == DB_LAST);
        end
    end

    always_ff @(posedge clk100_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < 3; i++) begin
                st[i]  <= IDLE;
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                unique case (st[i])
                    IDLE: begin
                        if (low[i]) begin
                            st[i]  <= DB_PRESS;
                            cnt[i] <= '0;
                        end
                    end
                    DB_PRESS: begin
                        if (!low[i]) begin
                            st[i]  <= IDLE;
                            cnt[i] <= '0;
                        end else if (cnt[i] == DB_LAST) begin
                            st[i]  <= PRESSED;
                            cnt[i] <= '0;
                        end else if (cnt[i] != DB_MAX) begin
                            cnt[i] <= cnt[i] + CW'(1);
                        end
                    end
                    PRESSED: begin
                        if (!low[i]) begin
                            st[i]  <= DB_RELEASE;
                            cnt[i] <= '0;
                        end
                    end
                    DB_RELEASE: begin
                        if (low[i]) begin
                            st[i]  <= PRESSED;
                            cnt[i] <= '0;
                        end else if (cnt[i] == DB_LAST) begin
                            st[i]  <= IDLE;
                            cnt[i] <= '0;
                        end else if (cnt[i] != DB_MAX) begin
                            cnt[i] <= cnt[i] + CW'(1);
                        end
                    end
                endcase
            end
        end
    end

`ifdef COUNTER_CTRL_AUTOREPEAT_EN
    localparam int RW = $clog2(REPEAT_CYCLES + 1);
    localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);

    logic [RW-1:0] rep_cnt;
    logic          rep_evt;

    // Repeats only fire while the key is still sampled low, so a release never adds a trailing load.
    assign rep_evt = (st[0] == PRESSED) && low[0] && (rep_cnt == REP_LAST);

    always_ff @(posedge clk100_i or posedge rst_i) begin
        if (rst_i) begin
            rep_cnt <= '0;
        end else if (st[0] != PRESSED || !low[0] || rep_evt) begin
            rep_cnt <= '0;
        end else begin
            rep_cnt <= rep_cnt + RW'(1);
        end
    end

    assign load_evt = evt[0] | rep_evt;
`else
    assign load_evt = evt[0];
`endif

    // Clear has priority over load; hold only blocks loads.
    assign load_ok = load_evt && !hold_o && !evt[2];

    always_ff @(posedge clk100_i or posedge rst_i) begin
        if (rst_i) begin
            load_o  <= 1'b0;
            clear_o <= 1'b0;
            data_o  <= '0;
            hold_o  <= 1'b0;
        end else begin
            load_o  <= load_ok;
            clear_o <= evt[2];
            if (load_ok) begin
                data_o <= sw_i;
            end
            if (evt[1]) begin
                hold_o <= ~hold_o;
            end
        end
    end

    assign state_o = st[0];

endmodule
